key_sched_stream: RTL and testbench
===================================

KEY_SCHED_STREAM -- requirements
Module: key_sched_stream

Interface
REQ-001 The block SHALL have parameter WORD_W, default 9, giving the round-key word width in bits.
REQ-002 The block SHALL have parameter NUM_WORDS, default 16, giving the number of key words; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter LANES, default 3, giving the number of consecutive-index words emitted per beat.
REQ-004 The block SHALL have parameter IDX_W, default 7, giving the round-index width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port key_load, input, 1 bit, a strobe that captures key_in.
REQ-008 The block SHALL have port key_in, input, NUM_WORDS*WORD_W bits; word k SHALL be key_in[k*WORD_W +: WORD_W].
REQ-009 The block SHALL have port start, input, 1 bit, a request to begin a stream.
REQ-010 The block SHALL have port start_idx, input, IDX_W bits, the first round index.
REQ-011 The block SHALL have port count, input, IDX_W bits, the number of beats requested.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the consumer ready.
REQ-013 The block SHALL have port out_valid, output, 1 bit, indicating the beat is valid.
REQ-014 The block SHALL have port out_key, output, LANES*WORD_W bits; lane l SHALL be at [l*WORD_W +: WORD_W].
REQ-015 The block SHALL have port out_idx, output, IDX_W bits, the index of lane 0.
REQ-016 The block SHALL have port out_last, output, 1 bit, marking the final beat of a stream.
REQ-017 The block SHALL have ports busy and key_loaded, outputs, 1 bit each, giving state status.

Function
REQ-018 Lane l of a beat with base index b SHALL use idx = (b+l) mod 2^IDX_W, word w = (NUM_WORDS - (idx mod NUM_WORDS)) mod NUM_WORDS, and out = key_word[w] XOR idx, with idx zero-extended or truncated to WORD_W.
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 In IDLE, start SHALL be accepted when key_loaded=1 and count!=0; otherwise start SHALL be ignored.
REQ-021 On acceptance, the block SHALL go to RUN, and out_valid SHALL rise on the next cycle with base=start_idx.
REQ-022 A beat SHALL transfer on a cycle where out_valid=1 and out_ready=1.
REQ-023 Each transfer SHALL advance the base by LANES modulo 2^IDX_W.
REQ-024 out_valid SHALL remain asserted, with no bubbles, until count beats have transferred.
REQ-025 While out_valid=1 and out_ready=0, out_key, out_idx and out_last SHALL hold stable.
REQ-026 out_last SHALL be 1 only on beat number count.
REQ-027 On transfer of the last beat, the block SHALL return to IDLE, and out_valid SHALL be 0 on the next cycle.
REQ-028 busy SHALL equal (state==RUN).
REQ-029 key_load in IDLE SHALL capture key_in at the clock edge and set key_loaded=1.
REQ-030 key_load during RUN SHALL be ignored, keeping the key frozen for the stream.
REQ-031 start during RUN SHALL be ignored.
REQ-032 If key_load and start occur in the same IDLE cycle, the new key SHALL be captured, and start SHALL be accepted only if key_loaded was already 1; the first beat SHALL use the new key.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE, out_valid=0, out_last=0, busy=0, key_loaded=0, out_key=0, out_idx=0 and the key register=0.
REQ-035 Reset asserted mid-stream SHALL abort the stream with no further beats.
REQ-036 Reset release SHALL take effect on the clock edge.

Structure
REQ-037 The shared package key_pkg SHALL hold the state enum and the default parameter constants.
REQ-038 The per-lane word select and XOR SHALL be a combinational sub-module key_word_sel, instantiated LANES times.

Verification
REQ-039 Use defaults with key word k = 0x100|k; load the key, then start_idx=0, count=1, ready=1 -> one beat with lanes {0x100,0x10E,0x10C}, out_idx=0, out_last=1.
REQ-040 Start with start_idx=126, count=2 -> beat 1 lanes {0x17C,0x17E,0x100}, out_idx=126; beat 2 lanes {0x10E,0x10C,0x10E}, out_idx=1, out_last=1.
REQ-041 Apply count=3 and toggle out_ready low for 4 cycles mid-stream -> outputs stay stable while stalled, exactly 3 transfers occur, and the last beat carries out_last.
REQ-042 Apply start before any key_load, and start with count=0 -> out_valid stays 0 and busy stays 0.
REQ-043 Apply key_load with a new key during RUN -> the stream finishes with the old key, and the next stream uses the old key.
REQ-044 Assert rst_n low during beat 2 of 4 -> out_valid=0 immediately, key_loaded=0, and start is ignored until a reload.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default sizing for the streaming round-key scheduler.
package key_pkg;

    localparam int DEF_WORD_W    = 9;
    localparam int DEF_NUM_WORDS = 16;
    localparam int DEF_LANES     = 3;
    localparam int DEF_IDX_W     = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/key_word_sel.sv
// One output lane: picks key word (-idx mod NUM_WORDS) and whitens it with idx.
module key_word_sel
    import key_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic [NUM_WORDS*WORD_W-1:0] key,
    input  logic [IDX_W-1:0]            idx,
    output logic [WORD_W-1:0]           word
);

    localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [SEL_W-1:0]  sel;
    logic [WORD_W-1:0] idx_w;

    // Power-of-two word count makes (N - i mod N) mod N a plain negation.
    assign sel   = SEL_W'('0 - {{SEL_W{1'b0}}, idx});
    assign idx_w = WORD_W'({{WORD_W{1'b0}}, idx});
    assign word  = key[sel*WORD_W +: WORD_W] ^ idx_w;

endmodule

// File: rtl/key_sched_stream.sv
// Streams LANES whitened round-key words per beat over a valid/ready port.
module key_sched_stream
    import key_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int LANES     = DEF_LANES,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_load,
    input  logic [NUM_WORDS*WORD_W-1:0] key_in,
    input  logic                        start,
    input  logic [IDX_W-1:0]            start_idx,
    input  logic [IDX_W-1:0]            count,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [LANES*WORD_W-1:0]     out_key,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic                        key_loaded
);

    localparam int KEY_W = NUM_WORDS * WORD_W;

    state_t                    state;
    logic [KEY_W-1:0]          key_q;
    logic [KEY_W-1:0]          key_src;
    logic [IDX_W-1:0]          rem;
    logic [IDX_W-1:0]          base_nxt;
    logic [LANES*WORD_W-1:0]   lanes;
    logic                      load_ok;
    logic                      accept;
    logic                      xfer;

    assign load_ok  = (state == IDLE) && key_load;
    assign accept   = (state == IDLE) && start && key_loaded && (count != '0);
    assign xfer     = out_valid && out_ready;
    // A key loaded alongside an accepted start feeds the very first beat.
    assign key_src  = load_ok ? key_in : key_q;
    assign base_nxt = accept ? start_idx : out_idx + IDX_W'(LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        key_word_sel #(
            .WORD_W    (WORD_W),
            .NUM_WORDS (NUM_WORDS),
            .IDX_W     (IDX_W)
        ) u_sel (
            .key  (key_src),
            .idx  (base_nxt + IDX_W'(l)),
            .word (lanes[l*WORD_W +: WORD_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_q      <= '0;
            key_loaded <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_key    <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            rem        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_ok) begin
                        key_q      <= key_in;
                        key_loaded <= 1'b1;
                    end
                    if (accept) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_key   <= lanes;
                        out_idx   <= base_nxt;
                        out_last  <= (count == IDX_W'(1));
                        rem       <= count;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_key  <= lanes;
                            out_idx  <= base_nxt;
                            out_last <= (rem == IDX_W'(2));
                            rem      <= rem - IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_stream.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares.
module tb_key_sched_stream;

    localparam int W = 9;
    localparam int N = 16;
    localparam int L = 3;
    localparam int I = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_load;
    logic [N*W-1:0]   key_in;
    logic             start;
    logic [I-1:0]     start_idx;
    logic [I-1:0]     count;
    logic             out_ready;
    logic             out_valid;
    logic [L*W-1:0]   out_key;
    logic [I-1:0]     out_idx;
    logic             out_last;
    logic             busy;
    logic             key_loaded;

    typedef struct {
        logic [L*W-1:0] key;
        logic [I-1:0]   idx;
        logic           last;
    } beat_t;

    beat_t q[$];
    int    km[N];
    bit    loaded_m;
    int    n_cmp;
    int    n_bad;
    int    pops;

    key_sched_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .start      (start),
        .start_idx  (start_idx),
        .count      (count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_key    (out_key),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .key_loaded (key_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_word(input int ix);
        int w;
        w = (N - (ix % N)) % N;
        return W'((km[w] ^ ix) & ((1 << W) - 1));
    endfunction

    task automatic push_stream(input int sidx, input int cnt);
        beat_t e;
        int    b;
        b = sidx;
        for (int k = 1; k <= cnt; k++) begin
            for (int l = 0; l < L; l++)
                e.key[l*W +: W] = model_word((b + l) % (1 << I));
            e.idx  = I'(b);
            e.last = (k == cnt);
            q.push_back(e);
            b = (b + L) % (1 << I);
        end
    endtask

    function automatic logic [N*W-1:0] rand_key();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic check_reset();
        check("rst_valid", 64'(out_valid), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_keyld", 64'(key_loaded), 0);
        check("rst_key", 64'(out_key), 0);
        check("rst_idx", 64'(out_idx), 0);
    endtask

    task automatic load_key(input logic [N*W-1:0] nk);
        @(posedge clk); #1;
        key_in   = nk;
        key_load = 1'b1;
        for (int k = 0; k < N; k++) km[k] = int'(nk[k*W +: W]);
        loaded_m = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 4 cycles mid-stream
    task automatic issue(input int sidx, input int cnt, input bit do_load,
                         input logic [N*W-1:0] nk, input int mode,
                         input bit mid_load, input bit auto_push);
        bit acc;
        int c;
        @(posedge clk); #1;
        start     = 1'b1;
        start_idx = I'(sidx);
        count     = I'(cnt);
        key_in    = nk;
        key_load  = do_load;
        out_ready = 1'b1;
        acc = loaded_m && (cnt != 0);
        if (do_load) begin
            for (int k = 0; k < N; k++) km[k] = int'(nk[k*W +: W]);
            loaded_m = 1'b1;
        end
        if (acc && auto_push) push_stream(sidx, cnt);
        @(posedge clk); #1;
        start    = 1'b0;
        key_load = 1'b0;
        if (!acc) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("ign_valid", 64'(out_valid), 0);
            check("ign_busy", 64'(busy), 0);
            return;
        end
        c = 0;
        while (c < 400 && q.size() != 0) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(c >= 1 && c < 5);
            endcase
            if (mid_load && c == 2) begin
                key_in   = rand_key();
                key_load = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        key_load  = 1'b0;
        out_ready = 1'b1;
        if (q.size() != 0) begin
            check("stream_timeout", 64'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
        check("end_valid", 64'(out_valid), 0);
        check("end_busy", 64'(busy), 0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 64'(out_idx), 64'hFFFF);
            end else begin
                e = q[0];
                check("beat_key", 64'(out_key), 64'(e.key));
                check("beat_idx", 64'(out_idx), 64'(e.idx));
                check("beat_last", 64'(out_last), 64'(e.last));
                check("beat_busy", 64'(busy), 1);
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] dk;
        beat_t          e;
        int             c;
        int             p0;
        rst_n = 1'b0; key_load = 1'b0; key_in = '0; start = 1'b0;
        start_idx = '0; count = '0; out_ready = 1'b1;
        n_cmp = 0; n_bad = 0; pops = 0; loaded_m = 1'b0;
        for (int k = 0; k < N; k++) km[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // start before any key is loaded
        issue(5, 2, 1'b0, '0, 0, 1'b0, 1'b1);

        for (int k = 0; k < N; k++) dk[k*W +: W] = W'(9'h100 | k);
        load_key(dk);
        check("keyld_set", 64'(key_loaded), 1);

        issue(9, 0, 1'b0, dk, 0, 1'b0, 1'b1);

        e.key = {9'h10C, 9'h10E, 9'h100}; e.idx = 7'd0; e.last = 1'b1;
        q.push_back(e);
        issue(0, 1, 1'b0, dk, 0, 1'b0, 1'b0);

        e.key = {9'h100, 9'h17E, 9'h17C}; e.idx = 7'd126; e.last = 1'b0;
        q.push_back(e);
        e.key = {9'h10E, 9'h10C, 9'h10E}; e.idx = 7'd1; e.last = 1'b1;
        q.push_back(e);
        issue(126, 2, 1'b0, dk, 0, 1'b0, 1'b0);

        p0 = pops;
        issue(40, 3, 1'b0, dk, 2, 1'b0, 1'b1);
        check("stall_xfers", 64'(pops - p0), 3);

        // key_load during RUN must not disturb this or the next stream
        issue(20, 6, 1'b0, dk, 0, 1'b1, 1'b1);
        issue(77, 2, 1'b0, dk, 0, 1'b0, 1'b1);

        // new key together with start: first beat uses the new key
        issue(3, 3, 1'b1, rand_key(), 0, 1'b0, 1'b1);

        for (int t = 0; t < 30; t++) begin
            int cnt;
            cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            issue(int'($urandom_range(0, 127)), cnt,
                  ($urandom_range(0, 3) == 0), rand_key(),
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 1'b1);
        end

        // reset during beat 2 of 4
        @(posedge clk); #1;
        start = 1'b1; start_idx = 7'd50; count = 7'd4; out_ready = 1'b1;
        push_stream(50, 4);
        p0 = pops;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (pops < p0 + 1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("rst_beat1_seen", 64'(pops - p0), 1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset();
        q.delete();
        loaded_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(10, 3, 1'b0, '0, 0, 1'b0, 1'b1);
        issue(11, 2, 1'b1, rand_key(), 0, 1'b0, 1'b1);
        check("reload_keyld", 64'(key_loaded), 1);
        issue(12, 4, 1'b0, '0, 1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
